// File: rtl/gigex_rx_cmd_deframer.sv
// Deframes GigEx receive bytes on one channel into 32-bit MSB-first commands,
// buffers them in a FWFT FIFO and throttles GigEx through the nRF flags.
//
// state  | meaning
// S_IDLE | waiting for byte 0 (bits 31:24)
// S_B1   | byte 0 held, waiting for bits 23:16
// S_B2   | bytes 0-1 held, waiting for bits 15:8
// S_B3   | bytes 0-2 held, next byte completes and pushes the word
module gigex_rx_cmd_deframer #(
  parameter int CHANNEL   = 0,
  parameter int DEPTH     = 16,
  parameter int SKID      = 4,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               Q,
  input  logic                     nRx,
  input  logic [2:0]               RC,
  output logic [7:0]               nRF,
  output logic [31:0]              cmd_out,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]     frame_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [CNT_WIDTH-1:0]     timeout_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]        IDLE_LOAD = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0]        FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0]        THRESH    = LW'(DEPTH - SKID);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_B1 = 2'd1, S_B2 = 2'd2, S_B3 = 2'd3} state_t;

  state_t          state;
  logic [23:0]     asm_q;
  logic [TW-1:0]   idle_cnt;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            nrf_ok;

  logic accept, push_req, full, do_push, do_pop, tmo_fire;

  assign accept   = !nRx && (RC == 3'(CHANNEL));
  assign push_req = accept && (state == S_B3);
  assign full     = (fifo_level == FULL_LVL);
  assign do_push  = push_req && !full;
  assign do_pop   = cmd_valid && cmd_ready;
  assign tmo_fire = !accept && (state != S_IDLE) && (idle_cnt == '0);

  // Idle timer is a down-counter reloaded on every accepted byte; terminal count
  // is reached after TIMEOUT consecutive cycles without one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      asm_q    <= '0;
      idle_cnt <= '0;
    end else if (accept) begin
      idle_cnt <= IDLE_LOAD;
      case (state)
        S_IDLE: begin asm_q[23:16] <= Q; state <= S_B1; end
        S_B1:   begin asm_q[15:8]  <= Q; state <= S_B2; end
        S_B2:   begin asm_q[7:0]   <= Q; state <= S_B3; end
        S_B3:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (idle_cnt == '0) begin
        state <= S_IDLE;
        asm_q <= '0;
      end else begin
        idle_cnt <= idle_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {asm_q, Q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign cmd_valid = (fifo_level != '0);
  assign cmd_out   = cmd_valid ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_count   <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
      nrf_ok        <= 1'b0;
    end else begin
      nrf_ok <= (fifo_level < THRESH);
      if (do_push && frame_count != CNT_MAX)             frame_count   <= frame_count + 1'b1;
      if (push_req && full && drop_count != CNT_MAX)     drop_count    <= drop_count + 1'b1;
      if (tmo_fire && timeout_count != CNT_MAX)          timeout_count <= timeout_count + 1'b1;
    end
  end

  // Only the served channel ever reports "not full"; the rest stay throttled.
  assign nRF = nrf_ok ? (8'h01 << CHANNEL) : 8'h00;

endmodule

// File: tb/tb_gigex_rx_cmd_deframer.sv
// Bench for gigex_rx_cmd_deframer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_gigex_rx_cmd_deframer;
  localparam int CH    = 0;
  localparam int DEPTH = 16;
  localparam int SKID  = 4;
  localparam int TMO   = 1024;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  Q = 8'h00;
  logic        nRx = 1'b1;
  logic [2:0]  RC = 3'd0;
  logic        cmd_ready = 1'b0;
  logic [7:0]  nRF;
  logic [31:0] cmd_out;
  logic        cmd_valid;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CW-1:0] frame_count, drop_count, timeout_count;

  always #5 clk = ~clk;

  gigex_rx_cmd_deframer #(
    .CHANNEL(CH), .DEPTH(DEPTH), .SKID(SKID), .TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .Q(Q), .nRx(nRx), .RC(RC), .nRF(nRF),
    .cmd_out(cmd_out), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .fifo_level(fifo_level), .frame_count(frame_count),
    .drop_count(drop_count), .timeout_count(timeout_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered commands and a queue of pending bytes.
  logic [31:0] mq[$];
  logic [7:0]  part[$];
  int idle = 0;
  int m_frame = 0, m_drop = 0, m_tmo = 0;
  bit m_nrf = 1'b0;

  always @(posedge clk or negedge rst) begin
    int lvl;
    logic [31:0] w;
    if (!rst) begin
      mq.delete();
      part.delete();
      idle = 0; m_frame = 0; m_drop = 0; m_tmo = 0; m_nrf = 1'b0;
    end else begin
      lvl = mq.size();
      m_nrf = !(lvl >= DEPTH - SKID);
      if (lvl > 0 && cmd_ready) void'(mq.pop_front());
      if (!nRx && RC == CH) begin
        part.push_back(Q);
        idle = 0;
        if (part.size() == 4) begin
          w = {part[0], part[1], part[2], part[3]};
          part.delete();
          if (lvl == DEPTH) begin
            if (m_drop < CMAX) m_drop++;
          end else begin
            mq.push_back(w);
            if (m_frame < CMAX) m_frame++;
          end
        end
      end else if (part.size() > 0) begin
        idle++;
        if (idle == TMO) begin
          part.delete();
          idle = 0;
          if (m_tmo < CMAX) m_tmo++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmd_valid", 32'(cmd_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("cmd_out", cmd_out, mq[0]);
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("frame_count", 32'(frame_count), 32'(m_frame));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("timeout_count", 32'(timeout_count), 32'(m_tmo));
    chk("nRF", 32'(nRF), m_nrf ? 32'(8'h01 << CH) : 32'h0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [2:0] ch, input logic [7:0] b);
    nRx = 1'b0; RC = ch; Q = b;
    step();
    nRx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(3'(CH), w[31 - 8*i -: 8]);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    chk("rst_nRF", 32'(nRF), 32'h0);
    chk("rst_valid", 32'(cmd_valid), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    #1 rst = 1'b0;
    step();
    chk("init_nRF", 32'(nRF), 32'h0);
    chk("init_out", cmd_out, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("nRF_open", 32'(nRF), 32'h01);

    // basic frame
    cmd_ready = 1'b1;
    send_word(32'h12345678);
    chk("t1_out", cmd_out, 32'h12345678);
    chk("t1_valid", 32'(cmd_valid), 32'h1);
    chk("t1_frames", 32'(frame_count), 32'd1);
    step();

    // foreign channel interleave
    send_byte(3'd0, 8'hDE); send_byte(3'd3, 8'hAA);
    send_byte(3'd0, 8'hAD); send_byte(3'd3, 8'hBB);
    send_byte(3'd0, 8'hBE); send_byte(3'd0, 8'hEF);
    chk("t2_out", cmd_out, 32'hDEADBEEF);
    chk("t2_frames", 32'(frame_count), 32'd2);
    step();
    chk("t2_empty", 32'(cmd_valid), 32'h0);

    // fill past full with consumer stalled
    pulse_reset();
    cmd_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      send_word(32'hC0DE0000 + 32'(k));
      if (k == 12) begin
        chk("t3_lvl12", 32'(fifo_level), 32'd12);
        chk("t3_nrf_lag", 32'(nRF), 32'h01);
        step();
        chk("t3_nrf_full", 32'(nRF), 32'h00);
      end
    end
    step();
    chk("t3_level", 32'(fifo_level), 32'd16);
    chk("t3_drop", 32'(drop_count), 32'd1);
    chk("t3_frames", 32'(frame_count), 32'd16);
    for (int k = 1; k <= 16; k++) begin
      chk("t3_drain", cmd_out, 32'hC0DE0000 + 32'(k));
      cmd_ready = 1'b1;
      step();
    end
    step();
    chk("t3_drained", 32'(fifo_level), 32'd0);
    chk("t3_nrf_open", 32'(nRF), 32'h01);

    // timeout, then a byte arriving exactly on the last idle cycle
    send_byte(3'(CH), 8'hAA); send_byte(3'(CH), 8'hBB);
    repeat (TMO) step();
    send_word(32'h01020304);
    chk("t4_tmo", 32'(timeout_count), 32'd1);
    chk("t4_out", cmd_out, 32'h01020304);
    send_byte(3'(CH), 8'h11); send_byte(3'(CH), 8'h22); send_byte(3'(CH), 8'h33);
    repeat (TMO - 1) step();
    send_byte(3'(CH), 8'h44);
    chk("t4_edge_tmo", 32'(timeout_count), 32'd1);
    chk("t4_edge_out", cmd_out, 32'h11223344);

    // random traffic
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int c = 0; c < 200; c++) begin
        int r;
        cmd_ready = ($urandom_range(1, 100) <= rdy_pct);
        r = $urandom_range(0, 9);
        if (r < 6)      send_byte(3'(CH), 8'($urandom));
        else if (r < 8) send_byte(3'($urandom_range(1, 7)), 8'($urandom));
        else            step();
      end
    end

    // reset mid-frame
    cmd_ready = 1'b0;
    send_byte(3'(CH), 8'h11); send_byte(3'(CH), 8'h22); send_byte(3'(CH), 8'h33);
    pulse_reset();
    send_word(32'hCAFEF00D);
    chk("t5_out", cmd_out, 32'hCAFEF00D);
    chk("t5_frames", 32'(frame_count), 32'd1);
    chk("t5_drop", 32'(drop_count), 32'd0);
    chk("t5_tmo", 32'(timeout_count), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gigex_rx_cmd_deframer.md
Name: gigex_rx_cmd_deframer

Overview:
- Sits on the GigEx receive interface (Q, nRx, RC, nRF), directly upstream of the per-module command path into the MicroBlaze and rst_controller.
- Gathers bytes from one GigEx receive channel into 32-bit commands, most-significant byte first.
- Buffers complete commands in a first-word-fall-through (FWFT) FIFO and presents them on a valid/ready stream.
- Throttles GigEx through the active-low channel-full flags and counts frames, drops and timeouts for firmware readback.

Parameters:
- CHANNEL, 0, GigEx receive channel (0-7) accepted; bytes on any other channel are discarded.
- DEPTH, 16, command FIFO depth in 32-bit words; power of 2, minimum 4.
- SKID, 4, free-slot margin below which nRF[CHANNEL] is asserted full; covers GigEx flag latency; 1 <= SKID < DEPTH.
- TIMEOUT, 1024, idle cycles allowed between bytes of a partially received command before it is discarded; >= 2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock (125 MHz eth_clk domain).
- rst  input  1  asynchronous reset, active-low.
- Q  input  8  receive byte from GigEx.
- nRx  input  1  receive byte valid, active-low.
- RC  input  3  receive byte channel.
- nRF  output  8  receive FIFO-full flag per channel to GigEx, active-low (0 = full).
- cmd_out  output  32  FIFO head command.
- cmd_valid  output  1  FIFO non-empty.
- cmd_ready  input  1  consumer accepts cmd_out this cycle.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- frame_count  output  CNT_WIDTH  commands written to the FIFO.
- drop_count  output  CNT_WIDTH  complete commands dropped because the FIFO was full.
- timeout_count  output  CNT_WIDTH  partial commands discarded by timeout.

Behaviour:
- Reset (rst low, asynchronous)
  - Clears the byte index, assembly register, idle counter, FIFO pointers and all three counters.
  - Reset values: nRF = 8'h00, cmd_valid = 0, cmd_out = 0, fifo_level = 0.
- Byte accept: a byte is accepted when nRx == 0 and RC == CHANNEL on the rising clk edge. Inputs are used directly; the top level registers them.
- Assembly state machine, 2-bit byte index:
  - IDLE (index 0): accepted byte goes to bits 31:24; go to B1.
  - B1: accepted byte goes to bits 23:16; go to B2.
  - B2: accepted byte goes to bits 15:8; go to B3.
  - B3: accepted byte goes to bits 7:0 and the full word is pushed; go to IDLE.
- Push:
  - Full is judged on registered fifo_level == DEPTH. There is no bypass, so a same-cycle pop does not make room.
  - Not full: the word is written and frame_count increments.
  - Full: the word is discarded and drop_count increments.
  - The state machine returns to IDLE in both cases.
- Latency: word written on the edge that samples byte 4; cmd_valid = 1 and cmd_out valid on the following cycle (FWFT).
- Pop:
  - When cmd_valid & cmd_ready, the head advances.
  - cmd_out holds steady while cmd_valid = 1 and cmd_ready = 0.
  - cmd_ready while empty has no effect.
- Simultaneous push and pop: both take effect and fifo_level is unchanged; the full check still uses the pre-edge level.
- Timeout:
  - The idle counter clears on every accepted byte and counts while index != 0.
  - When it reaches TIMEOUT: discard the partial word, go to IDLE, increment timeout_count.
  - A byte accepted in the timeout cycle wins: no timeout, the byte is appended.
- Flow control (registered, one-cycle lag):
  - nRF[CHANNEL] <= 0 when fifo_level >= DEPTH-SKID, else 1.
  - All other nRF bits are held 0 permanently.
- Foreign-channel bytes (nRx == 0, RC != CHANNEL):
  - Ignored and not counted.
  - They do not clear the idle counter.
- Counters: saturate at all-ones; no wrap.
- Pointers: wrap modulo DEPTH; one extra level bit distinguishes full from empty.
- Reset mid-frame: the partial word is lost and not counted; the first accepted byte after reset release is treated as byte 0.

Test Plan:
- Bytes 0x12,0x34,0x56,0x78 on channel 0, cmd_ready=1 -> cmd_out=0x12345678, cmd_valid one cycle after the 4th byte; frame_count=1.
- Interleave channel 3 bytes 0xAA,0xBB between channel 0 bytes 0xDE,0xAD,0xBE,0xEF -> single command 0xDEADBEEF; no other output.
- cmd_ready=0, send 17 commands with DEPTH=16, SKID=4:
  - nRF[0] goes 0 the cycle after fifo_level reaches 12.
  - fifo_level=16, drop_count=1, frame_count=16.
  - Draining the FIFO returns commands 1..16 in order; nRF[0] returns to 1 below 12.
- Send 2 bytes, idle 1024 cycles, then 0x01,0x02,0x03,0x04 -> timeout_count=1, cmd_out=0x01020304.
- Pull rst low after byte 3 of a frame, release, send 0xCAFEF00D -> cmd_out=0xCAFEF00D; all counters 1/0/0; nRF=8'h00 during reset.
